// File: rtl/arduino_gpio_tx.sv
// arduino_gpio_tx: sends the current target box code to the Arduino
// over a 3-bit bus with a four-phase req/ack handshake and timeout.
module arduino_gpio_tx #(
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] box_code,
    input  logic       send_valid,
    output logic       send_ready,
    input  logic       gpio_ack,
    output logic [2:0] gpio_data,
    output logic       gpio_req,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_timeout
);

    localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ?
                             SETUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HIGH,
        REQ_LOW
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ack_m;
    logic          ack_s;

    // Never start a transfer while the Arduino still holds ack high.
    assign send_ready = (state == IDLE) && !ack_s;

    // Two-flop synchronizer for the asynchronous ack pin.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= gpio_ack;
            ack_s <= ack_m;
        end
    end

    // Handshake FSM with registered outputs and a saturating cycle counter.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            gpio_data  <= 3'b000;
            gpio_req   <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_timeout <= 1'b0;
            if (cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (send_valid && send_ready) begin
                        gpio_data <= box_code;
                        state     <= SETUP;
                        busy      <= 1'b1;
                        cnt       <= '0;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state    <= REQ_HIGH;
                        gpio_req <= 1'b1;
                        cnt      <= '0;
                    end
                end
                REQ_HIGH: begin
                    // An ack arriving on the last cycle still wins.
                    if (ack_s) begin
                        state    <= REQ_LOW;
                        gpio_req <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == TO_LAST) begin
                        state      <= IDLE;
                        gpio_req   <= 1'b0;
                        busy       <= 1'b0;
                        tx_timeout <= 1'b1;
                    end
                end
                REQ_LOW: begin
                    if (!ack_s) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        tx_timeout <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    gpio_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arduino_gpio_tx.sv
// tb_arduino_gpio_tx: directed scenarios for the Arduino GPIO transmitter
// with SETUP_CYCLES=4 and TIMEOUT_CYCLES=100.
module tb_arduino_gpio_tx;

    logic       clk;
    logic       reset;
    logic [2:0] box_code;
    logic       send_valid;
    logic       send_ready;
    logic       gpio_ack;
    logic [2:0] gpio_data;
    logic       gpio_req;
    logic       busy;
    logic       tx_done;
    logic       tx_timeout;

    int total;
    int bad;

    arduino_gpio_tx #(
        .SETUP_CYCLES  (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .box_code  (box_code),
        .send_valid(send_valid),
        .send_ready(send_ready),
        .gpio_ack  (gpio_ack),
        .gpio_data (gpio_data),
        .gpio_req  (gpio_req),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_timeout(tx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge; outputs are sampled and inputs driven there.
    task automatic step();
        @(negedge clk);
    endtask

    // Bounded wait for gpio_req to reach a level; expiry is a failure.
    task automatic wait_req(input logic lvl, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            if (gpio_req === lvl) begin
                hit = 1;
                break;
            end
            step();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: gpio_req never reached %0d", tag, lvl);
        end
    endtask

    // Bounded wait for a tx_done pulse; expiry is a failure.
    task automatic wait_done(input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx_done === 1'b1) begin
                hit = 1;
                break;
            end
            step();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: tx_done never pulsed", tag);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        send_valid = 1'b0;
        box_code   = 3'd0;
        gpio_ack   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        total++;
        if (gpio_data !== 3'd0) begin
            bad++;
            $display("FAIL rst_data: got %0d want 0", gpio_data);
        end
        total++;
        if ({gpio_req, busy, tx_done, tx_timeout} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_flags: got %b want 0000",
                     {gpio_req, busy, tx_done, tx_timeout});
        end
        total++;
        if (send_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready: got %b want 1", send_ready);
        end
    endtask

    task automatic test_normal();
        int dn;
        box_code   = 3'd5;
        send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        total++;
        if (gpio_data !== 3'd5 || busy !== 1'b1) begin
            bad++;
            $display("FAIL norm_t1: got data=%0d busy=%b want 5 1",
                     gpio_data, busy);
        end
        repeat (3) step();
        total++;
        if (gpio_req !== 1'b0) begin
            bad++;
            $display("FAIL norm_t4: got req=%b want 0", gpio_req);
        end
        step();
        total++;
        if (gpio_req !== 1'b1) begin
            bad++;
            $display("FAIL norm_t5: got req=%b want 1", gpio_req);
        end
        repeat (10) step();
        gpio_ack = 1'b1;
        repeat (2) step();
        total++;
        if (gpio_req !== 1'b1) begin
            bad++;
            $display("FAIL norm_ack2: got req=%b want 1", gpio_req);
        end
        step();
        total++;
        if (gpio_req !== 1'b0) begin
            bad++;
            $display("FAIL norm_ack3: got req=%b want 0", gpio_req);
        end
        repeat (5) step();
        gpio_ack = 1'b0;
        repeat (2) step();
        total++;
        if (tx_done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL norm_pre_done: got done=%b busy=%b want 0 1",
                     tx_done, busy);
        end
        step();
        total++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || send_ready !== 1'b1) begin
            bad++;
            $display("FAIL norm_done: got done=%b busy=%b rdy=%b want 1 0 1",
                     tx_done, busy, send_ready);
        end
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_done === 1'b1 || busy !== 1'b0) dn++;
        end
        total++;
        if (dn != 0) begin
            bad++;
            $display("FAIL norm_after: got %0d bad cycles want 0", dn);
        end
    endtask

    task automatic test_timeout();
        int hi;
        int to;
        int dn;
        box_code   = 3'd3;
        send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        hi = 0;
        to = 0;
        dn = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (gpio_req === 1'b1) hi++;
            if (tx_timeout === 1'b1) to++;
            if (tx_done === 1'b1) dn++;
        end
        total++;
        if (hi != 100) begin
            bad++;
            $display("FAIL to_req_len: got %0d want 100", hi);
        end
        total++;
        if (to != 1 || dn != 0) begin
            bad++;
            $display("FAIL to_pulses: got to=%0d done=%0d want 1 0", to, dn);
        end
        total++;
        if (gpio_data !== 3'd3 || gpio_req !== 1'b0) begin
            bad++;
            $display("FAIL to_hold: got data=%0d req=%b want 3 0",
                     gpio_data, gpio_req);
        end
    endtask

    task automatic test_stuck_ack();
        int to;
        int rdy;
        box_code   = 3'd6;
        send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        wait_req(1'b1, "stuck_req_up");
        gpio_ack = 1'b1;
        to  = 0;
        rdy = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (tx_timeout === 1'b1) to++;
            if (send_ready !== 1'b0) rdy++;
        end
        total++;
        if (to != 1) begin
            bad++;
            $display("FAIL stuck_to: got %0d pulses want 1", to);
        end
        total++;
        if (rdy != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stuck_ready: got %0d ready cycles busy=%b want 0 0",
                     rdy, busy);
        end
        gpio_ack = 1'b0;
        step();
        total++;
        if (send_ready !== 1'b0) begin
            bad++;
            $display("FAIL stuck_rel1: got %b want 0", send_ready);
        end
        step();
        total++;
        if (send_ready !== 1'b1) begin
            bad++;
            $display("FAIL stuck_rel2: got %b want 1", send_ready);
        end
    endtask

    task automatic test_ignore_busy();
        box_code   = 3'd5;
        send_valid = 1'b1;
        step();
        box_code = 3'd2;
        wait_req(1'b1, "ign_req_up");
        total++;
        if (gpio_data !== 3'd5) begin
            bad++;
            $display("FAIL ign_hold_hi: got %0d want 5", gpio_data);
        end
        gpio_ack = 1'b1;
        wait_req(1'b0, "ign_req_dn");
        total++;
        if (gpio_data !== 3'd5) begin
            bad++;
            $display("FAIL ign_hold_lo: got %0d want 5", gpio_data);
        end
        gpio_ack = 1'b0;
        wait_done("ign_done");
        total++;
        if (gpio_data !== 3'd5 || send_ready !== 1'b1) begin
            bad++;
            $display("FAIL ign_done_cyc: got data=%0d rdy=%b want 5 1",
                     gpio_data, send_ready);
        end
        step();
        send_valid = 1'b0;
        total++;
        if (gpio_data !== 3'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ign_b2b: got data=%0d busy=%b want 2 1",
                     gpio_data, busy);
        end
        wait_req(1'b1, "ign2_req_up");
        gpio_ack = 1'b1;
        wait_req(1'b0, "ign2_req_dn");
        gpio_ack = 1'b0;
        wait_done("ign2_done");
        total++;
        if (gpio_data !== 3'd2) begin
            bad++;
            $display("FAIL ign2_data: got %0d want 2", gpio_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pl;
        box_code   = 3'd4;
        send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        wait_req(1'b1, "rmid_req_up");
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (gpio_req !== 1'b0 || busy !== 1'b0 || gpio_data !== 3'd0) begin
            bad++;
            $display("FAIL rmid_async: got req=%b busy=%b data=%0d want 0 0 0",
                     gpio_req, busy, gpio_data);
        end
        step();
        step();
        reset = 1'b0;
        pl = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_done === 1'b1 || tx_timeout === 1'b1) pl++;
        end
        total++;
        if (pl != 0 || send_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_after: got pulses=%0d rdy=%b want 0 1",
                     pl, send_ready);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        send_valid = 1'b0;
        box_code   = 3'd0;
        gpio_ack   = 1'b0;
        test_reset();
        test_normal();
        test_timeout();
        test_stuck_ack();
        test_ignore_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arduino_gpio_tx.md
# arduino_gpio_tx

Transmit side of the FPGA–Arduino GPIO link. The sensor path carries the hit box address from the Arduino into the FPGA; this block carries the current target box code from the game FSM out to the Arduino, so the Arduino can arm or light the matching box. Transfers use a 3-bit parallel data bus and a four-phase req/ack handshake with timeout. Upstream, the game FSM feeds the block through a valid/ready handshake.

## Interface
Parameters:
- SETUP_CYCLES, 50: cycles gpio_data is stable before gpio_req rises (1 µs at 50 MHz); must be ≥1.
- TIMEOUT_CYCLES, 500000: maximum cycles spent waiting for each ack edge (10 ms); must be ≥2.

Ports:
- CLOCK_50  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- box_code  in  3  target box code (0–7; 0 = clear all targets).
- send_valid  in  1  box_code is valid.
- send_ready  out  1  block accepts a code this cycle.
- gpio_ack  in  1  Arduino acknowledge; asynchronous, 2-flop synchronized internally (ack_s).
- gpio_data  out  3  registered code driven to the Arduino.
- gpio_req  out  1  registered request strobe.
- busy  out  1  high in any state other than IDLE.
- tx_done  out  1  one-cycle pulse on handshake completion.
- tx_timeout  out  1  one-cycle pulse on handshake abort.

## Operation
- States: IDLE, SETUP, REQ_HIGH, REQ_LOW.
- send_ready is combinational: (state==IDLE) && !ack_s.
- **IDLE.** On send_valid && send_ready:
  - box_code is captured into gpio_data.
  - Next state is SETUP and the cycle counter clears.
- **SETUP.** gpio_req=0. After SETUP_CYCLES cycles in SETUP, go to REQ_HIGH and clear the counter.
- **REQ_HIGH.** gpio_req=1.
  - ack_s=1: go to REQ_LOW and clear the counter.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: go to IDLE and pulse tx_timeout.
- **REQ_LOW.** gpio_req=0.
  - ack_s=0: go to IDLE and pulse tx_done.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: go to IDLE and pulse tx_timeout.
- gpio_data holds its value from capture until the next acceptance, including through IDLE and after a timeout. box_code and send_valid are ignored while busy.
- Simultaneous awaited ack edge and timeout expiry in the same cycle: the ack wins and no timeout is flagged.
- ack stuck high after a REQ_LOW timeout: send_ready stays 0 until ack_s falls, so a new transfer never starts against a high ack.
- Counter width is $clog2(max(SETUP_CYCLES, TIMEOUT_CYCLES)+1). The counter saturates and never wraps.
- tx_done and tx_timeout are mutually exclusive and never high for two consecutive cycles.

## Timing
- Reset values, applied asynchronously: state=IDLE, gpio_data=3'b000, gpio_req=0, busy=0, tx_done=0, tx_timeout=0, counter=0, both synchronizer flops=0.
- Reset asserted mid-transfer forces gpio_req low immediately, without waiting for a clock edge.
- Acceptance edge at cycle T:
  - T+1: gpio_data valid, busy=1.
  - T+1+SETUP_CYCLES: gpio_req rises.
- ack path: a gpio_ack edge is visible in ack_s 2 cycles later. gpio_req reacts 1 cycle after that, giving 3 cycles from ack pin to req pin.
- tx_done and tx_timeout are registered. Each is high during the first IDLE cycle, and busy=0 in that same cycle.
- Fastest back-to-back rate: with ack_s already low, send_ready is high in the tx_done cycle, so a new acceptance can occur there.
- Timeout duration: gpio_req stays high for exactly TIMEOUT_CYCLES cycles in REQ_HIGH when no ack arrives.

## Test plan
- **Reset.** Assert reset for 3 cycles, then release.
  - Required: all outputs at reset values; send_ready=1 with gpio_ack=0.
- **Normal transfer.** SETUP_CYCLES=4. Drive box_code=5 with send_valid pulse at T. The Arduino model raises ack 10 cycles after req rises and drops it 5 cycles after req falls.
  - Required: gpio_data=5 at T+1; gpio_req=1 at T+5; gpio_req falls 3 cycles after ack rises; single tx_done pulse; busy low afterwards.
- **Timeout in REQ_HIGH.** TIMEOUT_CYCLES=100, no ack, code 3.
  - Required: gpio_req high for exactly 100 cycles, then low; one tx_timeout pulse; no tx_done; gpio_data stays 3.
- **Stuck ack.** Model raises ack and never drops it.
  - Required: REQ_LOW times out with a tx_timeout pulse; send_ready stays 0 while ack is high; send_ready rises 2 cycles after ack is released.
- **Input ignored while busy.** Hold send_valid=1 and change box_code 5→2 mid-transfer.
  - Required: gpio_data stays 5 through completion; code 2 is accepted in the tx_done cycle; second transfer shows gpio_data=2.
- **Reset mid-transfer.** Assert reset asynchronously (mid-cycle) while in REQ_HIGH.
  - Required: gpio_req and busy go to 0 before the next clock edge; gpio_data=0; no tx_done or tx_timeout pulse.
